mem_arbiter: RTL and testbench

Two-requester arbiter that shares one `mem_system` cache instance between the instruction-fetch port (read-only) and the data-memory port (read/write). It owns the cache's `Addr`/`DataIn`/`Rd`/`Wr` inputs, grants one requester per transaction, and routes `Done`/`DataOut`/`CacheHit` back to the owner. Data requests have priority, and a burst limit bounds instruction starvation. It sits between fetch/memory stages and a unified `mem_system`.

---
 rtl/mem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one mem_system cache between the instruction-fetch
// port (read-only) and the data port (read/write). Data requests win in IDLE
// unless the fetch port has waited through D_BURST_MAX consecutive D grants.
// The granted request reaches the cache in the same cycle it is granted, and
// Done/DataOut/CacheHit are routed back only to the current owner.
module mem_arbiter #(
  parameter int unsigned D_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IAddr,
  input  logic        IRd,
  input  logic [15:0] DAddr,
  input  logic [15:0] DDataIn,
  input  logic        DRd,
  input  logic        DWr,
  output logic [15:0] IDataOut,
  output logic [15:0] DDataOut,
  output logic        IDone,
  output logic        DDone,
  output logic        IStall,
  output logic        DStall,
  output logic        ICacheHit,
  output logic        DCacheHit,
  output logic [15:0] MemAddr,
  output logic [15:0] MemDataIn,
  output logic        MemRd,
  output logic        MemWr,
  input  logic [15:0] MemDataOut,
  input  logic        MemDone,
  input  logic        MemStall,
  input  logic        MemCacheHit,
  input  logic        MemErr,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_D = 2'd1,
    SERVE_I = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LIM = 4'(D_BURST_MAX);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  burst_cnt_r;
  logic [3:0]  burst_cnt_nxt_s;
  logic        err_p_r;
  logic        err_set_s;
  logic [15:0] addr_r;
  logic        op_rd_r;
  logic        op_wr_r;

  logic        d_req_s;
  logic        idle_s;
  logic        serve_d_s;
  logic        serve_i_s;
  logic        burst_block_s;
  logic        grant_d_s;
  logic        grant_i_s;
  logic        own_d_s;
  logic        own_i_s;

  // The cache's stall indication carries no information the arbiter needs;
  // completion is taken from MemDone alone.
  logic        unused_mem_stall_s;
  assign unused_mem_stall_s = MemStall;

  // Reset masks all grants and completions so nothing leaks out while the
  // arbiter and the cache are being reset together.
  assign d_req_s       = DRd | DWr;
  assign idle_s        = (state_r == IDLE) & ~rst;
  assign serve_d_s     = (state_r == SERVE_D) & ~rst;
  assign serve_i_s     = (state_r == SERVE_I) & ~rst;
  assign burst_block_s = IRd & (burst_cnt_r == BURST_LIM);
  assign grant_d_s     = idle_s & d_req_s & ~burst_block_s;
  assign grant_i_s     = idle_s & ~grant_d_s & IRd;
  assign own_d_s       = grant_d_s | serve_d_s;
  assign own_i_s       = grant_i_s | serve_i_s;

  assign DDone     = serve_d_s & MemDone;
  assign IDone     = serve_i_s & MemDone;
  assign DDataOut  = DDone ? MemDataOut : 16'h0000;
  assign IDataOut  = IDone ? MemDataOut : 16'h0000;
  assign DCacheHit = DDone & MemCacheHit;
  assign ICacheHit = IDone & MemCacheHit;
  assign DStall    = d_req_s & ~DDone;
  assign IStall    = IRd & ~IDone;
  assign err       = err_p_r | MemErr;

  // Route the owner's request to the cache; Rd/Wr come from the latched
  // operation during service so a dropped request still completes.
  always_comb begin
    MemAddr   = 16'h0000;
    MemDataIn = 16'h0000;
    MemRd     = 1'b0;
    MemWr     = 1'b0;
    if (own_d_s) begin
      MemAddr   = DAddr;
      MemDataIn = DDataIn;
      if (serve_d_s) begin
        MemRd = op_rd_r;
        MemWr = op_wr_r;
      end else begin
        MemRd = DRd;
        MemWr = DWr;
      end
    end else if (own_i_s) begin
      MemAddr   = IAddr;
      MemDataIn = 16'h0000;
      MemRd     = 1'b1;
      MemWr     = 1'b0;
    end else begin
      MemAddr   = 16'h0000;
      MemDataIn = 16'h0000;
      MemRd     = 1'b0;
      MemWr     = 1'b0;
    end
  end

  // Next state: grant from IDLE, return to IDLE on the cache's completion.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          state_nxt_s = SERVE_D;
        end else if (grant_i_s) begin
          state_nxt_s = SERVE_I;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SERVE_D: begin
        if (MemDone) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SERVE_D;
        end
      end
      SERVE_I: begin
        if (MemDone) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SERVE_I;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Burst counter: counts D grants that made a waiting fetch wait longer.
  always_comb begin
    burst_cnt_nxt_s = burst_cnt_r;
    if (grant_d_s) begin
      if (IRd) begin
        if (burst_cnt_r != 4'hF) begin
          burst_cnt_nxt_s = burst_cnt_r + 4'd1;
        end else begin
          burst_cnt_nxt_s = 4'hF;
        end
      end else begin
        burst_cnt_nxt_s = 4'd0;
      end
    end else if (grant_i_s) begin
      burst_cnt_nxt_s = 4'd0;
    end else begin
      burst_cnt_nxt_s = burst_cnt_r;
    end
  end

  // Protocol violations: illegal D op, spurious completion, or the owner
  // withdrawing or moving its request while the cache is working on it.
  always_comb begin
    err_set_s = 1'b0;
    case (state_r)
      IDLE:    err_set_s = MemDone;
      SERVE_D: err_set_s = ~d_req_s | (DAddr != addr_r);
      SERVE_I: err_set_s = ~IRd | (IAddr != addr_r);
      default: err_set_s = 1'b0;
    endcase
    err_set_s = err_set_s | (DRd & DWr);
  end

  // State, burst counter, sticky error and the captured request of the owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      burst_cnt_r <= 4'd0;
      err_p_r     <= 1'b0;
      addr_r      <= 16'h0000;
      op_rd_r     <= 1'b0;
      op_wr_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      burst_cnt_r <= burst_cnt_nxt_s;
      err_p_r     <= err_p_r | err_set_s;
      if (grant_d_s) begin
        addr_r  <= DAddr;
        op_rd_r <= DRd;
        op_wr_r <= DWr;
      end else if (grant_i_s) begin
        addr_r  <= IAddr;
        op_rd_r <= 1'b1;
        op_wr_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a behavioural direct-mapped cache stands in for
// mem_system, and a transaction-level model predicts grants and read data.
module tb_mem_arbiter;

  localparam int D_BURST_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] IAddr, DAddr, DDataIn;
  logic        IRd, DRd, DWr;
  logic [15:0] IDataOut, DDataOut;
  logic        IDone, DDone, IStall, DStall, ICacheHit, DCacheHit;
  logic [15:0] MemAddr, MemDataIn;
  logic        MemRd, MemWr;
  logic        err;

  // cache stand-in
  logic [15:0] cmem [0:65535];
  logic        cval [0:15];
  logic [15:0] ctag [0:15];
  logic        cdirty [0:15];
  int          cstate, ccount;
  logic [15:0] caddr, cdata, c_dout;
  logic        cwr, chit, c_done, c_hit;
  logic        done_force, mem_err_force;
  logic        mem_done_s, mem_stall_s;
  logic [3:0]  cidx_s;
  logic        hit_now_s;
  int          lat_now_s;

  logic [15:0] ref_mem [0:65535];
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.D_BURST_MAX(D_BURST_MAX)) dut (
    .clk(clk), .rst(rst),
    .IAddr(IAddr), .IRd(IRd),
    .DAddr(DAddr), .DDataIn(DDataIn), .DRd(DRd), .DWr(DWr),
    .IDataOut(IDataOut), .DDataOut(DDataOut),
    .IDone(IDone), .DDone(DDone), .IStall(IStall), .DStall(DStall),
    .ICacheHit(ICacheHit), .DCacheHit(DCacheHit),
    .MemAddr(MemAddr), .MemDataIn(MemDataIn), .MemRd(MemRd), .MemWr(MemWr),
    .MemDataOut(c_dout), .MemDone(mem_done_s), .MemStall(mem_stall_s),
    .MemCacheHit(c_hit), .MemErr(mem_err_force), .err(err)
  );

  assign mem_done_s  = c_done | done_force;
  assign mem_stall_s = (cstate != 0) && !c_done;
  assign cidx_s      = MemAddr[3:0];
  assign hit_now_s   = cval[cidx_s] && (ctag[cidx_s] == MemAddr);
  assign lat_now_s   = hit_now_s ? 2 : ((cval[cidx_s] && cdirty[cidx_s]) ? 10 : 6);

  // cache: hit completes 2 cycles after grant, clean miss 6, dirty miss 10
  always @(posedge clk) begin
    if (rst) begin
      cstate <= 0;
      c_done <= 1'b0;
      c_hit  <= 1'b0;
    end else begin
      case (cstate)
        0: begin
          c_done <= 1'b0;
          if (MemRd || MemWr) begin
            ccount <= lat_now_s - 1;
            caddr  <= MemAddr;
            cdata  <= MemDataIn;
            cwr    <= MemWr;
            chit   <= hit_now_s;
            cstate <= 1;
          end
        end
        1: begin
          if (ccount == 1) begin
            c_done <= 1'b1;
            c_hit  <= chit;
            c_dout <= cwr ? cdata : cmem[caddr];
            cval[caddr[3:0]]   <= 1'b1;
            ctag[caddr[3:0]]   <= caddr;
            cdirty[caddr[3:0]] <= chit ? (cdirty[caddr[3:0]] | cwr) : cwr;
            if (cwr) cmem[caddr] <= cdata;
            cstate <= 2;
          end else begin
            ccount <= ccount - 1;
          end
        end
        default: begin
          c_done <= 1'b0;
          cstate <= 0;
        end
      endcase
    end
  end

  function automatic logic [15:0] pick_addr();
    return 16'h0400 + 16'($urandom_range(0, 23));
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; IRd = 1'b0; DRd = 1'b0; DWr = 1'b0;
    done_force = 1'b0; mem_err_force = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // drive a lone D access; lat = cycle index of DDone (grant cycle is 0), -1 on timeout
  task automatic d_access(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                          output logic [15:0] rd, output int lat);
    lat = -1; rd = 16'h0000;
    @(posedge clk); #1;
    DAddr = addr; DDataIn = data; DRd = ~wr; DWr = wr;
    for (int c = 0; c < 60 && lat < 0; c++) begin
      @(negedge clk);
      if (DDone === 1'b1) begin lat = c; rd = DDataOut; end
    end
    @(posedge clk); #1;
    DRd = 1'b0; DWr = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; IRd = 1'b0; DRd = 1'b0; DWr = 1'b0;
    IAddr = 16'h0; DAddr = 16'h0; DDataIn = 16'h0;
    done_force = 1'b0; mem_err_force = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({IDone, DDone, IStall, DStall, ICacheHit, DCacheHit, MemRd, MemWr, err} !== 9'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 000000000",
               {IDone, DDone, IStall, DStall, ICacheHit, DCacheHit, MemRd, MemWr, err});
    end
    tests_run++;
    if ({IDataOut, DDataOut, MemAddr, MemDataIn} !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_buses: got %h %h %h %h expected zeros", IDataOut, DDataOut, MemAddr, MemDataIn);
    end
    tests_run++;
    if (dut.state_r != 2'd0 || dut.burst_cnt_r !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got state %0d burst %0d expected 0 0", dut.state_r, dut.burst_cnt_r);
    end
  endtask

  task automatic test_i_hit();
    apply_reset();
    cmem[16'h0040] <= 16'h1234; cval[0] <= 1'b1; ctag[0] <= 16'h0040; cdirty[0] <= 1'b0;
    ref_mem[16'h0040] = 16'h1234;
    @(posedge clk); #1;
    IRd = 1'b1; IAddr = 16'h0040;
    @(negedge clk);
    tests_run++;
    if (MemRd !== 1'b1 || MemWr !== 1'b0 || MemAddr !== 16'h0040 || IStall !== 1'b1) begin
      tests_failed++;
      $display("FAIL ihit_grant: got rd %b wr %b addr %h stall %b expected 1 0 0040 1", MemRd, MemWr, MemAddr, IStall);
    end
    @(negedge clk);
    tests_run++;
    if (IDone !== 1'b0) begin
      tests_failed++;
      $display("FAIL ihit_cycle1: got IDone %b expected 0", IDone);
    end
    @(negedge clk);
    tests_run++;
    if (IDone !== 1'b1 || IDataOut !== 16'h1234 || ICacheHit !== 1'b1 || DDone !== 1'b0 || IStall !== 1'b0) begin
      tests_failed++;
      $display("FAIL ihit_done: got done %b data %h hit %b ddone %b stall %b expected 1 1234 1 0 0",
               IDone, IDataOut, ICacheHit, DDone, IStall);
    end
    @(posedge clk); #1 IRd = 1'b0;
  endtask

  task automatic test_contention();
    int d_at, bad, i_at;
    logic [15:0] rd; int lat;
    d_at = -1; bad = 0; i_at = -1;
    @(posedge clk); #1;
    IRd = 1'b1; IAddr = 16'h0040; DWr = 1'b1; DAddr = 16'h0100; DDataIn = 16'hBEEF;
    @(negedge clk);
    tests_run++;
    if (MemWr !== 1'b1 || MemRd !== 1'b0 || MemAddr !== 16'h0100 || MemDataIn !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL cont_dgrant: got wr %b rd %b addr %h din %h expected 1 0 0100 beef", MemWr, MemRd, MemAddr, MemDataIn);
    end
    if (IStall !== 1'b1 || IDone !== 1'b0) bad++;
    for (int c = 1; c < 60 && d_at < 0; c++) begin
      @(negedge clk);
      if (IStall !== 1'b1 || IDone !== 1'b0) bad++;
      if (DDone === 1'b1) d_at = c;
    end
    tests_run++;
    if (d_at < 0 || bad != 0) begin
      tests_failed++;
      $display("FAIL cont_dfirst: got ddone_cycle %0d istall_bad %0d expected >=2 and 0", d_at, bad);
    end
    ref_mem[16'h0100] = 16'hBEEF;
    @(posedge clk); #1 DWr = 1'b0;
    @(negedge clk);
    tests_run++;
    if (MemRd !== 1'b1 || MemAddr !== 16'h0040 || IStall !== 1'b1) begin
      tests_failed++;
      $display("FAIL cont_igrant: got rd %b addr %h stall %b expected 1 0040 1", MemRd, MemAddr, IStall);
    end
    for (int c = 0; c < 60 && i_at < 0; c++) begin
      if (IDone === 1'b1) i_at = c;
      else @(negedge clk);
    end
    tests_run++;
    if (i_at < 0 || IDataOut !== ref_mem[16'h0040]) begin
      tests_failed++;
      $display("FAIL cont_idata: got idone_at %0d data %h expected done and %h", i_at, IDataOut, ref_mem[16'h0040]);
    end
    @(posedge clk); #1 IRd = 1'b0;
    d_access(1'b0, 16'h0100, 16'h0000, rd, lat);
    tests_run++;
    if (lat < 0 || rd !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL cont_readback: got %h (lat %0d) expected beef", rd, lat);
    end
  endtask

  task automatic test_starvation();
    int d_cnt; logic got_i; logic [3:0] burst_at_i; logic dstall_at_i;
    d_cnt = 0; got_i = 1'b0; burst_at_i = 4'hF; dstall_at_i = 1'b0;
    apply_reset();
    @(posedge clk); #1;
    IRd = 1'b1; IAddr = 16'h0048; DRd = 1'b1; DWr = 1'b0; DAddr = 16'h0050;
    for (int cyc = 0; cyc < 400 && !got_i; cyc++) begin
      @(negedge clk);
      if (IDone === 1'b1) begin
        got_i = 1'b1; burst_at_i = dut.burst_cnt_r; dstall_at_i = DStall;
      end else if (DDone === 1'b1) begin
        d_cnt++;
        @(posedge clk); #1 DAddr = DAddr + 16'd1;
      end
    end
    tests_run++;
    if (!got_i || d_cnt != D_BURST_MAX) begin
      tests_failed++;
      $display("FAIL starve_count: got i_served %b after %0d DDone expected 1 after %0d", got_i, d_cnt, D_BURST_MAX);
    end
    tests_run++;
    if (burst_at_i !== 4'd0 || dstall_at_i !== 1'b1) begin
      tests_failed++;
      $display("FAIL starve_burst: got burst %0d dstall %b expected 0 1", burst_at_i, dstall_at_i);
    end
    @(posedge clk); #1 IRd = 1'b0; DRd = 1'b0;
  endtask

  task automatic test_dirty_miss();
    logic [15:0] rd; int lat; int d_at, bad, i_at;
    d_at = -1; bad = 0; i_at = -1;
    d_access(1'b1, 16'h0203, 16'h1111, rd, lat);
    ref_mem[16'h0203] = 16'h1111;
    @(posedge clk); #1;
    IRd = 1'b1; IAddr = 16'h0040; DWr = 1'b1; DAddr = 16'h0313; DDataIn = 16'h2222;
    for (int c = 0; c < 60 && d_at < 0; c++) begin
      @(negedge clk);
      if (IStall !== 1'b1 || IDone !== 1'b0) bad++;
      if (DDone === 1'b1) d_at = c;
    end
    tests_run++;
    if (d_at != 10 || bad != 0) begin
      tests_failed++;
      $display("FAIL dirty_latency: got ddone_cycle %0d istall_bad %0d expected 10 and 0", d_at, bad);
    end
    ref_mem[16'h0313] = 16'h2222;
    @(posedge clk); #1 DWr = 1'b0;
    for (int c = 0; c < 60 && i_at < 0; c++) begin
      @(negedge clk);
      if (IDone === 1'b1) i_at = c;
    end
    tests_run++;
    if (i_at < 0 || IDataOut !== ref_mem[16'h0040]) begin
      tests_failed++;
      $display("FAIL dirty_ifetch: got idone_at %0d data %h expected done and %h", i_at, IDataOut, ref_mem[16'h0040]);
    end
    @(posedge clk); #1 IRd = 1'b0;
    d_access(1'b0, 16'h0313, 16'h0000, rd, lat);
    tests_run++;
    if (lat < 0 || rd !== 16'h2222) begin
      tests_failed++;
      $display("FAIL dirty_read_new: got %h expected 2222", rd);
    end
    d_access(1'b0, 16'h0203, 16'h0000, rd, lat);
    tests_run++;
    if (lat < 0 || rd !== 16'h1111) begin
      tests_failed++;
      $display("FAIL dirty_read_old: got %h expected 1111", rd);
    end
  endtask

  task automatic test_random();
    int owner, streak, nfail_local;
    logic i_pend, d_pend, d_wr;
    logic [15:0] i_addr, d_addr, d_data, exp_addr;
    logic exp_rd, exp_wr, exp_id, exp_dd;
    owner = 0; streak = 0; nfail_local = 0;
    i_pend = 1'b0; d_pend = 1'b0; d_wr = 1'b0;
    i_addr = 16'h0400; d_addr = 16'h0400; d_data = 16'h0; exp_addr = 16'h0;
    exp_rd = 1'b0; exp_wr = 1'b0; exp_id = 1'b0; exp_dd = 1'b0;
    apply_reset();
    for (int cyc = 0; cyc < 3000 && nfail_local < 10; cyc++) begin
      @(posedge clk); #1;
      if (exp_dd) d_pend = 1'b0;
      if (exp_id) i_pend = 1'b0;
      if (!d_pend && $urandom_range(0, 99) < 40) begin
        d_pend = 1'b1; d_wr = 1'($urandom_range(0, 1)); d_addr = pick_addr(); d_data = 16'($urandom);
      end
      if (!i_pend && $urandom_range(0, 99) < 50) begin
        i_pend = 1'b1; i_addr = pick_addr();
      end
      DRd = d_pend & ~d_wr; DWr = d_pend & d_wr; DAddr = d_addr; DDataIn = d_data;
      IRd = i_pend; IAddr = i_addr;
      @(negedge clk);
      if (owner == 0) begin
        if (d_pend && !(i_pend && streak == D_BURST_MAX)) begin
          owner = 1; streak = i_pend ? ((streak < 15) ? streak + 1 : 15) : 0;
          exp_rd = ~d_wr; exp_wr = d_wr; exp_addr = d_addr;
        end else if (i_pend) begin
          owner = 2; streak = 0; exp_rd = 1'b1; exp_wr = 1'b0; exp_addr = i_addr;
        end else begin
          exp_rd = 1'b0; exp_wr = 1'b0; exp_addr = 16'h0;
        end
      end
      exp_dd = (owner == 1) && mem_done_s;
      exp_id = (owner == 2) && mem_done_s;
      tests_run++;
      if (MemRd !== exp_rd || MemWr !== exp_wr || MemAddr !== exp_addr) begin
        tests_failed++; nfail_local++;
        $display("FAIL rand_mem_req cyc %0d: got rd %b wr %b addr %h expected %b %b %h",
                 cyc, MemRd, MemWr, MemAddr, exp_rd, exp_wr, exp_addr);
      end
      tests_run++;
      if (IDone !== exp_id || DDone !== exp_dd || IStall !== (i_pend & ~exp_id) ||
          DStall !== (d_pend & ~exp_dd) || err !== 1'b0) begin
        tests_failed++; nfail_local++;
        $display("FAIL rand_handshake cyc %0d: got idone %b ddone %b istall %b dstall %b err %b expected %b %b %b %b 0",
                 cyc, IDone, DDone, IStall, DStall, err, exp_id, exp_dd, i_pend & ~exp_id, d_pend & ~exp_dd);
      end
      if (exp_dd) begin
        if (d_wr) begin
          ref_mem[d_addr] = d_data;
        end else begin
          tests_run++;
          if (DDataOut !== ref_mem[d_addr]) begin
            tests_failed++; nfail_local++;
            $display("FAIL rand_dread cyc %0d addr %h: got %h expected %h", cyc, d_addr, DDataOut, ref_mem[d_addr]);
          end
        end
      end
      if (exp_id) begin
        tests_run++;
        if (IDataOut !== ref_mem[i_addr]) begin
          tests_failed++; nfail_local++;
          $display("FAIL rand_iread cyc %0d addr %h: got %h expected %h", cyc, i_addr, IDataOut, ref_mem[i_addr]);
        end
      end
      if (exp_dd || exp_id) owner = 0;
    end
    @(posedge clk); #1 IRd = 1'b0; DRd = 1'b0; DWr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    apply_reset();
    @(posedge clk); #1;
    DRd = 1'b1; DAddr = 16'h0777;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; DRd = 1'b0;
    @(negedge clk);
    if (DDone !== 1'b0 || MemRd !== 1'b0) bad++;
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (DDone !== 1'b0 || MemRd !== 1'b0 || dut.state_r != 2'd0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL reset_mid: got %0d cycles with Done/MemRd/non-IDLE expected 0", bad);
    end
  endtask

  task automatic test_err_drop();
    logic done_seen; int late_bad;
    done_seen = 1'b0; late_bad = 0;
    apply_reset();
    @(posedge clk); #1;
    DRd = 1'b1; DAddr = 16'h0999;
    @(negedge clk);
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_before_drop: got %b expected 0", err);
    end
    @(posedge clk); #1 DRd = 1'b0;
    @(negedge clk);
    if (DDone === 1'b1) done_seen = 1'b1;
    @(negedge clk);
    if (DDone === 1'b1) done_seen = 1'b1;
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_drop: got %b expected 1", err);
    end
    for (int c = 0; c < 40 && !done_seen; c++) begin
      @(negedge clk);
      if (DDone === 1'b1) done_seen = 1'b1;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (err !== 1'b1) late_bad++;
    end
    tests_run++;
    if (!done_seen || late_bad != 0) begin
      tests_failed++;
      $display("FAIL err_sticky: got completed %b err_low_cycles %0d expected 1 0", done_seen, late_bad);
    end
    apply_reset();
    @(negedge clk);
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_cleared: got %b expected 0", err);
    end
  endtask

  task automatic test_err_memdone();
    apply_reset();
    @(posedge clk); #1 done_force = 1'b1;
    @(negedge clk);
    tests_run++;
    if (IDone !== 1'b0 || DDone !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_done_pulse: got idone %b ddone %b expected 0 0", IDone, DDone);
    end
    @(posedge clk); #1 done_force = 1'b0;
    @(negedge clk);
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_idle_memdone: got %b expected 1", err);
    end
    apply_reset();
    @(posedge clk); #1 mem_err_force = 1'b1;
    @(negedge clk);
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_memerr_pass: got %b expected 1", err);
    end
    @(posedge clk); #1 mem_err_force = 1'b0;
    @(negedge clk);
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_memerr_release: got %b expected 0", err);
    end
  endtask

  initial begin
    rst = 1'b1; IRd = 1'b0; DRd = 1'b0; DWr = 1'b0;
    IAddr = 16'h0; DAddr = 16'h0; DDataIn = 16'h0;
    done_force = 1'b0; mem_err_force = 1'b0;
    c_dout <= 16'h0;
    for (int i = 0; i < 65536; i++) begin
      cmem[i] <= 16'h0;
      ref_mem[i] = 16'h0;
    end
    for (int i = 0; i < 16; i++) begin
      cval[i] <= 1'b0; ctag[i] <= 16'h0; cdirty[i] <= 1'b0;
    end
    test_reset();
    test_i_hit();
    test_contention();
    test_starvation();
    test_dirty_miss();
    test_random();
    test_reset_mid();
    test_err_drop();
    test_err_memdone();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
